// File: rtl/i2s_frame_scheduler.sv
// I2S transmit frame scheduler: derives lrclk from bclk, fetches one sample per
// half-frame from the left/right sources and holds it on tx_data for the serializer.
module i2s_frame_scheduler #(
    parameter int SLOT_BITS        = 16,
    parameter int DATA_W           = 16,
    parameter int HOLD_ON_UNDERRUN = 0
) (
    input  logic              bclk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] l_data,
    input  logic              l_valid,
    output logic              l_ready,
    input  logic [DATA_W-1:0] r_data,
    input  logic              r_valid,
    output logic              r_ready,
    output logic              lrclk,
    output logic [DATA_W-1:0] tx_data,
    output logic              frame_start,
    output logic [15:0]       frame_count,
    output logic              underrun_l,
    output logic              underrun_r,
    input  logic              underrun_clr,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = $clog2(SLOT_BITS);
    localparam logic [CNT_W-1:0] FETCH_SLOT = CNT_W'(SLOT_BITS - 2);
    localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(SLOT_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_LEFT  = 2'd2,
        ST_RIGHT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic              lrclk_q, lrclk_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [DATA_W-1:0] next_word_q, next_word_d;
    logic [DATA_W-1:0] last_l_q, last_l_d;
    logic [DATA_W-1:0] last_r_q, last_r_d;
    logic              frame_start_q, frame_start_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              underrun_l_q, underrun_l_d;
    logic              underrun_r_q, underrun_r_d;

    logic boundary;
    logic fetch;
    logic set_l, set_r;

    assign boundary = (slot_cnt_q == LAST_SLOT);
    assign fetch    = (slot_cnt_q == FETCH_SLOT);

    // All state moves on the falling bclk edge so the serializer sees stable data on the rising edge.
    always_ff @(negedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            slot_cnt_q    <= '0;
            lrclk_q       <= 1'b1;
            tx_data_q     <= '0;
            next_word_q   <= '0;
            last_l_q      <= '0;
            last_r_q      <= '0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
            underrun_l_q  <= 1'b0;
            underrun_r_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_cnt_q    <= slot_cnt_d;
            lrclk_q       <= lrclk_d;
            tx_data_q     <= tx_data_d;
            next_word_q   <= next_word_d;
            last_l_q      <= last_l_d;
            last_r_q      <= last_r_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            underrun_l_q  <= underrun_l_d;
            underrun_r_q  <= underrun_r_d;
        end
    end

    // Next state: enable is only looked at in IDLE and at the end of RIGHT.
    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_cnt_q + CNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                slot_cnt_d = '0;
                if (enable) state_d = ST_SYNC;
            end
            ST_SYNC:  if (boundary) state_d = ST_LEFT;
            ST_LEFT:  if (boundary) state_d = ST_RIGHT;
            ST_RIGHT: if (boundary) state_d = enable ? ST_LEFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (state_d != state_q) slot_cnt_d = '0;
    end

    // Outputs and datapath updates.
    always_comb begin
        l_ready       = fetch && ((state_q == ST_SYNC) || (state_q == ST_RIGHT));
        r_ready       = fetch && (state_q == ST_LEFT);
        set_l         = 1'b0;
        set_r         = 1'b0;
        next_word_d   = next_word_q;
        last_l_d      = last_l_q;
        last_r_d      = last_r_q;
        tx_data_d     = tx_data_q;
        frame_start_d = 1'b0;
        frame_count_d = frame_count_q;
        lrclk_d       = (state_d != ST_LEFT);

        if (l_ready) begin
            if (l_valid) begin
                next_word_d = l_data;
                last_l_d    = l_data;
            end else begin
                next_word_d = (HOLD_ON_UNDERRUN != 0) ? last_l_q : '0;
                set_l       = 1'b1;
            end
        end
        if (r_ready) begin
            if (r_valid) begin
                next_word_d = r_data;
                last_r_d    = r_data;
            end else begin
                next_word_d = (HOLD_ON_UNDERRUN != 0) ? last_r_q : '0;
                set_r       = 1'b1;
            end
        end

        if (boundary && (state_q != ST_IDLE)) begin
            tx_data_d = (state_d == ST_IDLE) ? '0 : next_word_q;
        end

        if ((state_d == ST_LEFT) && (state_q != ST_LEFT)) begin
            frame_start_d = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
        end

        // A new underrun outranks a clear arriving in the same cycle.
        underrun_l_d = set_l | (underrun_l_q & ~underrun_clr);
        underrun_r_d = set_r | (underrun_r_q & ~underrun_clr);
    end

    assign lrclk       = lrclk_q;
    assign tx_data     = tx_data_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;
    assign underrun_l  = underrun_l_q;
    assign underrun_r  = underrun_r_q;
    assign busy        = (state_q != ST_IDLE);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Bench for i2s_frame_scheduler: a zero-fill instance and a hold-last instance share
// the same stimulus; each has its own expected-word queue.
module tb_i2s_frame_scheduler;

    localparam int SLOT = 16;
    localparam int DW   = 16;

    logic          bclk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] l_data = '0;
    logic          l_valid = 1'b0;
    logic [DW-1:0] r_data = '0;
    logic          r_valid = 1'b0;
    logic          underrun_clr = 1'b0;

    logic          l_ready, r_ready, lrclk, frame_start, underrun_l, underrun_r, busy;
    logic [DW-1:0] tx_data;
    logic [15:0]   frame_count;
    logic [1:0]    state_dbg;

    logic          h_l_ready, h_r_ready, h_lrclk, h_frame_start, h_underrun_l, h_underrun_r, h_busy;
    logic [DW-1:0] h_tx_data;
    logic [15:0]   h_frame_count;
    logic [1:0]    h_state_dbg;

    i2s_frame_scheduler #(.SLOT_BITS(SLOT), .DATA_W(DW), .HOLD_ON_UNDERRUN(0)) dut (
        .bclk(bclk), .reset_n(reset_n), .enable(enable),
        .l_data(l_data), .l_valid(l_valid), .l_ready(l_ready),
        .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready),
        .lrclk(lrclk), .tx_data(tx_data), .frame_start(frame_start), .frame_count(frame_count),
        .underrun_l(underrun_l), .underrun_r(underrun_r), .underrun_clr(underrun_clr),
        .busy(busy), .state_dbg(state_dbg)
    );

    i2s_frame_scheduler #(.SLOT_BITS(SLOT), .DATA_W(DW), .HOLD_ON_UNDERRUN(1)) dut_h (
        .bclk(bclk), .reset_n(reset_n), .enable(enable),
        .l_data(l_data), .l_valid(l_valid), .l_ready(h_l_ready),
        .r_data(r_data), .r_valid(r_valid), .r_ready(h_r_ready),
        .lrclk(h_lrclk), .tx_data(h_tx_data), .frame_start(h_frame_start), .frame_count(h_frame_count),
        .underrun_l(h_underrun_l), .underrun_r(h_underrun_r), .underrun_clr(underrun_clr),
        .busy(h_busy), .state_dbg(h_state_dbg)
    );

    // Clock / reset
    always #5 bclk = ~bclk;

    int checks = 0;
    int errors = 0;

    // Scoreboard: {lrclk, word} expected for each half-frame, pushed at the fetch.
    logic [DW:0] exp_q[$];
    logic [DW:0] exph_q[$];
    logic        mon_en = 1'b0;
    logic [DW-1:0] last_l = '0;
    logic [DW-1:0] last_r = '0;
    int          since_tog = SLOT;
    int          since_tog_h = SLOT;
    logic [DW:0] cur_w = '0;
    logic [DW:0] cur_wh = '0;
    logic        prev_lr = 1'b1;
    logic        prev_lr_h = 1'b1;

    always @(posedge bclk) begin
        #2;
        if (!mon_en) begin
            since_tog = SLOT;
            prev_lr   = lrclk;
        end else begin
            if (l_ready) exp_q.push_back({1'b0, l_valid ? l_data : 16'h0000});
            if (r_ready) exp_q.push_back({1'b1, r_valid ? r_data : 16'h0000});
            if (lrclk !== prev_lr) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty: lrclk/tx %b/%h with no expected word", lrclk, tx_data);
                end else begin
                    cur_w = exp_q.pop_front();
                    if ({lrclk, tx_data} !== cur_w) begin
                        errors++;
                        $display("FAIL sb_word: got %b/%h exp %b/%h", lrclk, tx_data, cur_w[DW], cur_w[DW-1:0]);
                    end
                end
                since_tog = 0;
            end else if (since_tog < SLOT - 1) begin
                since_tog++;
                checks++;
                if ({lrclk, tx_data} !== cur_w) begin
                    errors++;
                    $display("FAIL sb_hold: got %b/%h exp %b/%h", lrclk, tx_data, cur_w[DW], cur_w[DW-1:0]);
                end
            end
            prev_lr = lrclk;
        end
    end

    always @(posedge bclk) begin
        #2;
        if (!mon_en) begin
            since_tog_h = SLOT;
            prev_lr_h   = h_lrclk;
        end else begin
            if (h_l_ready) begin
                if (l_valid) last_l = l_data;
                exph_q.push_back({1'b0, last_l});
            end
            if (h_r_ready) begin
                if (r_valid) last_r = r_data;
                exph_q.push_back({1'b1, last_r});
            end
            if (h_lrclk !== prev_lr_h) begin
                checks++;
                if (exph_q.size() == 0) begin
                    errors++;
                    $display("FAIL sbh_empty: lrclk/tx %b/%h with no expected word", h_lrclk, h_tx_data);
                end else begin
                    cur_wh = exph_q.pop_front();
                    if ({h_lrclk, h_tx_data} !== cur_wh) begin
                        errors++;
                        $display("FAIL sbh_word: got %b/%h exp %b/%h", h_lrclk, h_tx_data, cur_wh[DW], cur_wh[DW-1:0]);
                    end
                end
                since_tog_h = 0;
            end else if (since_tog_h < SLOT - 1) begin
                since_tog_h++;
                checks++;
                if ({h_lrclk, h_tx_data} !== cur_wh) begin
                    errors++;
                    $display("FAIL sbh_hold: got %b/%h exp %b/%h", h_lrclk, h_tx_data, cur_wh[DW], cur_wh[DW-1:0]);
                end
            end
            prev_lr_h = h_lrclk;
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        mon_en  = 1'b0;
        repeat (3) @(posedge bclk);
        checks++; if (lrclk !== 1'b1) begin errors++; $display("FAIL reset_lrclk: got %b exp 1", lrclk); end
        checks++; if (tx_data !== 16'h0000) begin errors++; $display("FAIL reset_tx: got %h exp 0000", tx_data); end
        checks++; if ({l_ready, r_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b exp 00", {l_ready, r_ready}); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b exp 0", frame_start); end
        checks++; if (frame_count !== 16'h0) begin errors++; $display("FAIL reset_fc: got %h exp 0000", frame_count); end
        checks++; if ({underrun_l, underrun_r} !== 2'b00) begin errors++; $display("FAIL reset_ur: got %b exp 00", {underrun_l, underrun_r}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", state_dbg); end
        reset_n = 1'b1;
        repeat (3) @(posedge bclk);
        checks++; if (busy !== 1'b0 || lrclk !== 1'b1) begin errors++; $display("FAIL idle_hold: busy/lrclk %b/%b exp 0/1", busy, lrclk); end
    endtask

    task automatic test_startup();
        int seg, slot;
        logic e_lr, e_fs, e_lrdy, e_rrdy;
        logic [DW-1:0] e_tx;
        logic [15:0] e_fc;
        l_data  = 16'h1234;
        r_data  = 16'hABCD;
        l_valid = 1'b1;
        r_valid = 1'b1;
        @(posedge bclk);
        mon_en = 1'b1;
        enable = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            @(posedge bclk);
            seg    = (i - 1) / SLOT;
            slot   = (i - 1) % SLOT;
            e_lr   = (seg == 0 || seg == 2);
            e_tx   = (seg == 0) ? 16'h0000 : (seg == 2) ? 16'hABCD : 16'h1234;
            e_fs   = (slot == 0) && (seg == 1 || seg == 3);
            e_lrdy = (slot == SLOT - 2) && (seg == 0 || seg == 2);
            e_rrdy = (slot == SLOT - 2) && (seg == 1 || seg == 3);
            e_fc   = (seg >= 3) ? 16'd2 : (seg >= 1) ? 16'd1 : 16'd0;
            checks++; if (lrclk !== e_lr) begin errors++; $display("FAIL start_lrclk @%0d: got %b exp %b", i, lrclk, e_lr); end
            checks++; if (tx_data !== e_tx) begin errors++; $display("FAIL start_tx @%0d: got %h exp %h", i, tx_data, e_tx); end
            checks++; if (frame_start !== e_fs) begin errors++; $display("FAIL start_fs @%0d: got %b exp %b", i, frame_start, e_fs); end
            checks++; if (l_ready !== e_lrdy) begin errors++; $display("FAIL start_lrdy @%0d: got %b exp %b", i, l_ready, e_lrdy); end
            checks++; if (r_ready !== e_rrdy) begin errors++; $display("FAIL start_rrdy @%0d: got %b exp %b", i, r_ready, e_rrdy); end
            checks++; if (frame_count !== e_fc) begin errors++; $display("FAIL start_fc @%0d: got %0d exp %0d", i, frame_count, e_fc); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy @%0d: got %b exp 1", i, busy); end
            // Only the fetch cycle may carry the real sample; everything else is noise.
            l_data = e_lrdy ? 16'h1234 : 16'($urandom_range(0, 16'hFFFF));
            r_data = e_rrdy ? 16'hABCD : 16'($urandom_range(0, 16'hFFFF));
        end
        l_data = 16'h1234;
        r_data = 16'hABCD;
    endtask

    task automatic test_underrun();
        bit found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(posedge bclk);
            if (r_ready) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL ur_wait: r_ready got 0 exp 1 within 64 cycles"); end
        r_valid = 1'b0;
        r_data  = 16'h5555;
        @(posedge bclk);
        r_valid = 1'b1;
        r_data  = 16'hABCD;
        checks++; if (underrun_r !== 1'b1) begin errors++; $display("FAIL ur_set: got %b exp 1", underrun_r); end
        checks++; if (h_underrun_r !== 1'b1) begin errors++; $display("FAIL ur_set_h: got %b exp 1", h_underrun_r); end
        checks++; if (underrun_l !== 1'b0) begin errors++; $display("FAIL ur_l_quiet: got %b exp 0", underrun_l); end
        repeat (40) @(posedge bclk);
        checks++; if (underrun_r !== 1'b1) begin errors++; $display("FAIL ur_sticky: got %b exp 1", underrun_r); end
        underrun_clr = 1'b1;
        @(posedge bclk);
        underrun_clr = 1'b0;
        @(posedge bclk);
        checks++; if ({underrun_r, h_underrun_r} !== 2'b00) begin errors++; $display("FAIL ur_clr: got %b exp 00", {underrun_r, h_underrun_r}); end
    endtask

    task automatic test_clear_collision();
        bit found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(posedge bclk);
            if (l_ready) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL cc_wait: l_ready got 0 exp 1 within 64 cycles"); end
        l_valid      = 1'b0;
        l_data       = 16'h7777;
        underrun_clr = 1'b1;
        @(posedge bclk);
        l_valid      = 1'b1;
        l_data       = 16'h1234;
        underrun_clr = 1'b0;
        checks++; if (underrun_l !== 1'b1) begin errors++; $display("FAIL cc_set_wins: got %b exp 1", underrun_l); end
        checks++; if (h_underrun_l !== 1'b1) begin errors++; $display("FAIL cc_set_wins_h: got %b exp 1", h_underrun_l); end
        repeat (4) @(posedge bclk);
        underrun_clr = 1'b1;
        @(posedge bclk);
        underrun_clr = 1'b0;
        @(posedge bclk);
        checks++; if (underrun_l !== 1'b0) begin errors++; $display("FAIL cc_clr: got %b exp 0", underrun_l); end
    endtask

    task automatic test_stop();
        bit found = 0;
        logic [15:0] fc_before;
        for (int i = 0; i < 64 && !found; i++) begin
            @(posedge bclk);
            if (frame_start) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL stop_wait: frame_start got 0 exp 1 within 64 cycles"); end
        enable    = 1'b0;
        fc_before = frame_count;
        for (int j = 1; j < 2 * SLOT; j++) begin
            @(posedge bclk);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stop_busy @%0d: got %b exp 1", j, busy); end
            checks++; if (lrclk !== (j >= SLOT)) begin errors++; $display("FAIL stop_lrclk @%0d: got %b exp %b", j, lrclk, (j >= SLOT)); end
        end
        @(posedge bclk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_idle_busy: got %b exp 0", busy); end
        checks++; if (lrclk !== 1'b1) begin errors++; $display("FAIL stop_idle_lrclk: got %b exp 1", lrclk); end
        checks++; if (tx_data !== 16'h0000) begin errors++; $display("FAIL stop_idle_tx: got %h exp 0000", tx_data); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL stop_idle_state: got %0d exp 0", state_dbg); end
        checks++; if (frame_count !== fc_before) begin errors++; $display("FAIL stop_fc: got %0d exp %0d", frame_count, fc_before); end
        // The left sample fetched in the final RIGHT half is never presented.
        checks++; if (exp_q.size() != 1) begin errors++; $display("FAIL stop_stale: got %0d pending exp 1", exp_q.size()); end
        checks++; if (exph_q.size() != 1) begin errors++; $display("FAIL stop_stale_h: got %0d pending exp 1", exph_q.size()); end
        exp_q.delete();
        exph_q.delete();
        repeat (8) @(posedge bclk);
        checks++; if (busy !== 1'b0 || frame_count !== fc_before) begin errors++; $display("FAIL stop_stay: busy/fc %b/%0d exp 0/%0d", busy, frame_count, fc_before); end
    endtask

    task automatic test_reset_mid_right();
        l_data = 16'h0F0F;
        @(posedge bclk);
        enable = 1'b1;
        repeat (40) @(posedge bclk);
        checks++; if (lrclk !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rst_pre: lrclk/busy %b/%b exp 1/1", lrclk, busy); end
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b exp 0", busy); end
        checks++; if (tx_data !== 16'h0000 || h_tx_data !== 16'h0000) begin errors++; $display("FAIL rst_async_tx: got %h/%h exp 0000", tx_data, h_tx_data); end
        checks++; if (lrclk !== 1'b1) begin errors++; $display("FAIL rst_async_lrclk: got %b exp 1", lrclk); end
        checks++; if (frame_count !== 16'h0) begin errors++; $display("FAIL rst_async_fc: got %0d exp 0", frame_count); end
        checks++; if ({l_ready, r_ready, frame_start} !== 3'b000) begin errors++; $display("FAIL rst_async_ctl: got %b exp 000", {l_ready, r_ready, frame_start}); end
        mon_en = 1'b0;
        exp_q.delete();
        exph_q.delete();
        last_l = '0;
        last_r = '0;
        repeat (2) @(posedge bclk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        for (int i = 1; i <= SLOT + 1; i++) begin
            @(posedge bclk);
            checks++; if (lrclk !== (i <= SLOT)) begin errors++; $display("FAIL restart_lrclk @%0d: got %b exp %b", i, lrclk, (i <= SLOT)); end
            checks++; if (tx_data !== ((i <= SLOT) ? 16'h0000 : 16'h0F0F)) begin errors++; $display("FAIL restart_tx @%0d: got %h", i, tx_data); end
        end
        checks++; if (frame_start !== 1'b1 || frame_count !== 16'd1) begin errors++; $display("FAIL restart_frame: fs/fc %b/%0d exp 1/1", frame_start, frame_count); end
        reset_n = 1'b0;
        mon_en  = 1'b0;
        enable  = 1'b0;
        @(posedge bclk);
    endtask

    initial begin
        test_reset();
        test_startup();
        test_underrun();
        test_clear_collision();
        test_stop();
        test_reset_mid_right();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_frame_scheduler.md
Name: i2s_frame_scheduler

Overview:
- Frame controller for the I2S transmit path of the audio codec interface.
- Generates lrclk from bclk.
- Shares the single parallel-to-serial transmitter between a left-channel and a right-channel sample source using ready/valid handshakes.
- Presents each channel's sample word on tx_data, held stable for its half-frame; handles underrun and clean start/stop.

Parameters:
- SLOT_BITS, 16, bclk cycles per half-frame (legal: 4..64).
- DATA_W, 16, sample width.
- HOLD_ON_UNDERRUN, 0, 0 = substitute zero on underrun; 1 = repeat the channel's last good sample.

Ports:
- bclk  in  1  bit clock; all state updates on falling edge of bclk.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  run request.
- l_data  in  DATA_W  left sample.
- l_valid  in  1  left sample available.
- l_ready  out  1  left sample accepted this cycle if l_valid.
- r_data  in  DATA_W  right sample.
- r_valid  in  1  right sample available.
- r_ready  out  1  right sample accepted this cycle if r_valid.
- lrclk  out  1  word select; 0 = left half-frame, 1 = right half-frame.
- tx_data  out  DATA_W  word for the serializer; stable for the whole half-frame.
- frame_start  out  1  one-cycle pulse on entry to LEFT.
- frame_count  out  16  LEFT entries since reset; wraps 0xFFFF->0.
- underrun_l  out  1  sticky left underrun flag.
- underrun_r  out  1  sticky right underrun flag.
- underrun_clr  in  1  clears both sticky flags.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async): state = IDLE, lrclk = 1, tx_data = 0, l_ready = r_ready = 0, frame_start = 0, frame_count = 0, underrun flags = 0, slot_cnt = 0, last-sample registers = 0.
- States: IDLE, SYNC, LEFT, RIGHT. slot_cnt counts 0..SLOT_BITS-1 and clears on every state entry.
- IDLE: lrclk = 1, tx_data = 0, no ready. If enable = 1, go to SYNC.
- SYNC: one half-frame with lrclk = 1 and tx_data = 0. Gives the serializer a clean lrclk falling edge.
- Fetch slot: at slot_cnt == SLOT_BITS-2, the scheduler asserts a one-cycle ready for the next channel:
  - l_ready in SYNC and RIGHT;
  - r_ready in LEFT.
- Handshake: a transfer occurs only when ready and valid are both high in the same cycle. Data is captured into a next-word register. valid without ready is ignored; the source holds it.
- Underrun: valid low in the fetch cycle. Next word = 0, or the last good sample of that channel if HOLD_ON_UNDERRUN = 1. The channel's underrun flag sets.
- Boundary cycle, slot_cnt == SLOT_BITS-1: in the same cycle, tx_data <= next word, lrclk toggles, and the state advances:
  - SYNC -> LEFT
  - LEFT -> RIGHT
  - RIGHT -> LEFT if enable = 1, else IDLE.
- Latency: a sample accepted in the fetch cycle appears on tx_data 2 bclk later, at the start of its half-frame.
- Entering LEFT: frame_start = 1 for exactly one cycle; frame_count increments.
- enable sampling: enable is sampled only in IDLE and at the RIGHT boundary.
  - Deassertion mid-frame completes the current frame (through end of RIGHT).
  - From SYNC or LEFT, the frame runs to completion; the right sample is still fetched.
- Entering IDLE from RIGHT: lrclk stays 1 and tx_data <= 0.
- Sticky flags: underrun_clr clears both. If a set and a clear occur in the same cycle, set wins.
- Reset asserted mid-operation: immediate return to reset values; no partial handshake completes.

Test Plan:
- Start-up (SLOT_BITS = 16, both valid constant, l_data = 0x1234, r_data = 0xABCD), raise enable from IDLE:
  - 16 cycles of lrclk = 1 with tx_data = 0;
  - then lrclk = 0 with tx_data = 0x1234 for 16 cycles;
  - then lrclk = 1 with 0xABCD;
  - frame_start pulses once per 32 cycles.
- Handshake timing: l_ready asserts exactly at slot_cnt 14 of SYNC/RIGHT and r_ready at slot_cnt 14 of LEFT, each one cycle wide. Changing l_data on any other cycle does not affect tx_data.
- Underrun, HOLD_ON_UNDERRUN = 0: drop r_valid for one fetch -> that RIGHT half carries 0x0000 and underrun_r = 1, held until underrun_clr. With HOLD_ON_UNDERRUN = 1 -> the RIGHT half carries 0xABCD.
- Clear collision: assert underrun_clr in the same cycle as a new left underrun -> underrun_l remains 1.
- Stop: drop enable during LEFT -> the RIGHT half completes, then IDLE with lrclk = 1, tx_data = 0, busy = 0. frame_count is unchanged after the stop.
- Async reset mid-RIGHT: all outputs return to reset values without waiting for a bclk edge. Re-enable restarts at SYNC.
